// File: rtl/fetch_target_queue.sv
// Fetch target queue: in-order decoupling FIFO between the branch predictor
// and the instruction-cache fetch stage. Each entry holds one fetch block
// (base PC, per-slot valid mask, predicted next PC). A redirect flushes every
// buffered block in a single cycle.
//
// Pointers carry one extra wrap bit above the index so that full and empty
// can be told apart without a separate occupancy counter; the occupancy seen
// on `count` is simply the pointer difference modulo 2*DEPTH.
module fetch_target_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_pc,
    input  logic [FETCH_WIDTH-1:0]   enq_mask,
    input  logic [31:0]              enq_npc,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [31:0]              deq_pc,
    output logic [FETCH_WIDTH-1:0]   deq_mask,
    output logic [31:0]              deq_npc,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Storage is deliberately unreset: its contents are only ever observed
    // through the head pointer, which reset/flush force onto an empty queue.
    logic [31:0]            pc_mem   [DEPTH];
    logic [FETCH_WIDTH-1:0] mask_mem [DEPTH];
    logic [31:0]            npc_mem  [DEPTH];

    logic [AW:0]   head;
    logic [AW:0]   tail;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;

    logic full;
    logic empty;
    logic enq_fire;
    logic enq_write;
    logic deq_fire;

    assign head_idx = head[AW-1:0];
    assign tail_idx = tail[AW-1:0];

    assign full  = (head_idx == tail_idx) && (head[AW] != tail[AW]);
    assign empty = (head == tail);

    // No same-cycle dequeue credit: a full queue refuses even if the head is
    // being consumed this cycle. Flush does not gate readiness; the predictor
    // discards its own in-flight block when it sees the redirect.
    assign enq_ready = rst_n && !full;
    assign deq_valid = !empty;

    // A handshake with an all-zero mask is accepted but carries no
    // instructions, so it is dropped rather than occupying an entry.
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign enq_write = enq_fire && (|enq_mask);
    assign deq_fire  = deq_valid && deq_ready && !flush;

    assign deq_pc   = pc_mem[head_idx];
    assign deq_mask = mask_mem[head_idx];
    assign deq_npc  = npc_mem[head_idx];

    assign count = tail - head;

    // Head/tail pointer update; reset and flush both collapse to empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_write) begin
                tail <= tail + PTR_ONE;
            end
            if (deq_fire) begin
                head <= head + PTR_ONE;
            end
        end
    end

    // Write the accepted block into the slot addressed by the tail.
    always_ff @(posedge clk) begin
        if (rst_n && enq_write) begin
            pc_mem[tail_idx]   <= enq_pc;
            mask_mem[tail_idx] <= enq_mask;
            npc_mem[tail_idx]  <= enq_npc;
        end
    end

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed bench for fetch_target_queue: hand-computed expectations for reset,
// single transfer, fill/drain, wrap-around streaming, zero-mask drop, flush
// and mid-operation reset.
module tb_fetch_target_queue;

    localparam int FW    = 4;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [FW-1:0] enq_mask;
    logic [31:0] enq_npc;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [FW-1:0] deq_mask;
    logic [31:0] deq_npc;
    logic        deq_ready;
    logic [$clog2(DEPTH):0] count;

    int vectors;
    int miscompares;

    fetch_target_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_mask  (enq_mask),
        .enq_npc   (enq_npc),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_mask  (deq_mask),
        .deq_npc   (deq_npc),
        .deq_ready (deq_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [FW-1:0] mask, input logic [31:0] npc);
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_mask  = mask;
        enq_npc   = npc;
        step();
        enq_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_pc    = '0;
        enq_mask  = '0;
        enq_npc   = '0;
        deq_ready = 1'b0;

        // Reset state
        step();
        step();
        check_val("rst_count", count, 0);
        check_val("rst_deq_valid", deq_valid, 0);
        check_val("rst_enq_ready", enq_ready, 0);
        rst_n = 1'b1;
        step();
        check_val("post_rst_enq_ready", enq_ready, 1);

        // Single block, one-cycle latency, then dequeue
        push(32'h1C00_0000, 4'b1111, 32'h1C00_0010);
        check_val("t1_deq_valid", deq_valid, 1);
        check_val("t1_pc", deq_pc, 32'h1C00_0000);
        check_val("t1_mask", deq_mask, 4'b1111);
        check_val("t1_npc", deq_npc, 32'h1C00_0010);
        check_val("t1_count", count, 1);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check_val("t1_drain_count", count, 0);
        check_val("t1_drain_valid", deq_valid, 0);

        // Fill to full, refused 9th offer, drain in order
        for (int i = 0; i < 8; i++) begin
            push(32'h1C00_0000 + 32'(16 * i), 4'b1111, 32'h1C00_0010 + 32'(16 * i));
        end
        check_val("t2_full_count", count, 8);
        check_val("t2_full_enq_ready", enq_ready, 0);
        step();
        check_val("t2_stable_pc", deq_pc, 32'h1C00_0000);
        check_val("t2_head_pc0", deq_pc, 32'h1C00_0000);
        enq_valid = 1'b1;
        enq_pc    = 32'hDEAD_BEEF;
        enq_mask  = 4'b1111;
        enq_npc   = 32'hDEAD_BEF0;
        deq_ready = 1'b1;
        step();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check_val("t2_after_9th_count", count, 7);
        for (int i = 1; i < 8; i++) begin
            check_val("t2_order_pc", deq_pc, 32'h1C00_0000 + 32'(16 * i));
            deq_ready = 1'b1;
            step();
            deq_ready = 1'b0;
        end
        check_val("t2_empty_count", count, 0);
        check_val("t2_empty_valid", deq_valid, 0);

        // Streaming with pointer wrap: count stays at one
        push(32'h1C00_0100, 4'b0011, 32'h1C00_0110);
        for (int k = 0; k < 20; k++) begin
            check_val("t3_count", count, 1);
            check_val("t3_pc", deq_pc, 32'h1C00_0100 + 32'(16 * k));
            enq_valid = 1'b1;
            enq_pc    = 32'h1C00_0100 + 32'(16 * (k + 1));
            enq_mask  = 4'b0011;
            enq_npc   = enq_pc + 32'd16;
            deq_ready = 1'b1;
            step();
        end
        enq_valid = 1'b0;
        check_val("t3_last_pc", deq_pc, 32'h1C00_0100 + 32'(16 * 20));
        step();
        deq_ready = 1'b0;
        check_val("t3_end_count", count, 0);

        // Zero-mask block is dropped
        push(32'h1C00_0020, 4'b0000, 32'h1C00_0030);
        check_val("t4_zero_count", count, 0);
        check_val("t4_zero_valid", deq_valid, 0);
        push(32'h1C00_0024, 4'b1100, 32'h1C00_0030);
        check_val("t4_count", count, 1);
        check_val("t4_pc", deq_pc, 32'h1C00_0024);
        check_val("t4_mask", deq_mask, 4'b1100);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check_val("t4_drain_count", count, 0);

        // Flush beats concurrent enqueue and dequeue
        for (int i = 0; i < 5; i++) begin
            push(32'h1C00_0200 + 32'(16 * i), 4'b1111, 32'h1C00_0210 + 32'(16 * i));
        end
        check_val("t5_count5", count, 5);
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_pc    = 32'h0000_0BAD;
        enq_mask  = 4'b1111;
        deq_ready = 1'b1;
        #1;
        check_val("t5_enq_ready_in_flush", enq_ready, 1);
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check_val("t5_flush_count", count, 0);
        check_val("t5_flush_valid", deq_valid, 0);
        push(32'h1C00_0300, 4'b0001, 32'h1C00_0310);
        check_val("t5_new_count", count, 1);
        check_val("t5_new_pc", deq_pc, 32'h1C00_0300);
        check_val("t5_new_npc", deq_npc, 32'h1C00_0310);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;

        // Mid-operation reset
        for (int i = 0; i < 3; i++) begin
            push(32'h1C00_0400 + 32'(16 * i), 4'b1111, 32'h1C00_0410 + 32'(16 * i));
        end
        check_val("t6_count3", count, 3);
        rst_n = 1'b0;
        step();
        check_val("t6_rst_count", count, 0);
        check_val("t6_rst_valid", deq_valid, 0);
        check_val("t6_rst_enq_ready", enq_ready, 0);
        rst_n = 1'b1;
        step();
        check_val("t6_rel_enq_ready", enq_ready, 1);
        check_val("t6_rel_count", count, 0);
        push(32'h1C00_0500, 4'b0110, 32'h1C00_0510);
        check_val("t6_new_count", count, 1);
        check_val("t6_new_pc", deq_pc, 32'h1C00_0500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
